// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode/execute sequencer: fetches a word from instruction memory,
// classifies it, drives the PC update and counts retired instructions.
module fetch_ctrl #(
    parameter int unsigned TIMEOUT = 15,
    parameter logic [5:0]  OP_HALT = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        zero_i,
    input  logic        ex_done_i,
    output logic [31:0] ir_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic        error_o,
    output logic [15:0] icount_o
);

    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    localparam logic [5:0] OpJump = 6'b000010;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StHalt, StError
    } state_e;

    state_e            state_q;
    logic [31:0]       ir_q;
    logic [15:0]       icount_q;
    logic [WaitW-1:0]  wait_q;
    logic [5:0]        opcode;
    logic              is_jump;
    logic              is_halt;
    logic              take_branch;

    assign opcode  = ir_q[31:26];
    assign is_jump = (opcode == OpJump);
    assign is_halt = (opcode == OP_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ir_q     <= 32'h0;
            icount_q <= 16'h0;
            wait_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    wait_q <= '0;
                    if (start_i) state_q <= StFetch;
                end
                StFetch: begin
                    // An ack on the last permitted wait cycle still wins over the timeout.
                    if (imem_ack_i) begin
                        ir_q    <= imem_data_i;
                        wait_q  <= '0;
                        state_q <= StDecode;
                    end else if (wait_q == WaitLast) begin
                        wait_q  <= '0;
                        state_q <= StError;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StDecode: begin
                    if (is_jump) begin
                        icount_q <= icount_q + 16'd1;
                        state_q  <= StFetch;
                    end else if (is_halt) begin
                        state_q <= StHalt;
                    end else begin
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (ex_done_i) begin
                        icount_q <= icount_q + 16'd1;
                        state_q  <= StFetch;
                    end
                end
                StHalt:  state_q <= StHalt;
                StError: state_q <= StError;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign take_branch = ((opcode == OpBeq) && zero_i) || ((opcode == OpBne) && !zero_i);

    // PC update is the only Mealy output: it fires in the cycle the decision is made.
    always_comb begin
        pc_we_o  = 1'b0;
        pc_sel_o = 2'd0;
        if (state_q == StDecode && is_jump) begin
            pc_we_o  = 1'b1;
            pc_sel_o = 2'd2;
        end else if (state_q == StExec && ex_done_i) begin
            pc_we_o  = 1'b1;
            pc_sel_o = take_branch ? 2'd1 : 2'd0;
        end
    end

    assign imem_req_o = (state_q == StFetch);
    assign busy_o     = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
    assign halted_o   = (state_q == StHalt);
    assign error_o    = (state_q == StError);
    assign ir_o       = ir_q;
    assign icount_o   = icount_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a per-cycle vector table for the main instruction flow,
// then hand-written sequences for timeout, reset abort and counter wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        zero_i = 1'b0;
    logic        ex_done_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] ir_o;
    logic        pc_we_o;
    logic [1:0]  pc_sel_o;
    logic        busy_o;
    logic        halted_o;
    logic        error_o;
    logic [15:0] icount_o;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .imem_req_o  (imem_req_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .zero_i      (zero_i),
        .ex_done_i   (ex_done_i),
        .ir_o        (ir_o),
        .pc_we_o     (pc_we_o),
        .pc_sel_o    (pc_sel_o),
        .busy_o      (busy_o),
        .halted_o    (halted_o),
        .error_o     (error_o),
        .icount_o    (icount_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        s;
        logic        a;
        logic [31:0] d;
        logic        z;
        logic        e;
        logic        req;
        logic        we;
        logic [1:0]  sel;
        logic        busy;
        logic        halt;
        logic        err;
        logic [15:0] ic;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, s, a, input logic [31:0] d, input logic z, e,
                       input logic req, we, input logic [1:0] sel, input logic busy, halt, err,
                       input logic [15:0] ic, input logic [31:0] ir);
        vec_t v;
        v.r = r; v.s = s; v.a = a; v.d = d; v.z = z; v.e = e;
        v.req = req; v.we = we; v.sel = sel; v.busy = busy; v.halt = halt; v.err = err;
        v.ic = ic; v.ir = ir;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic r, s, a, input logic [31:0] d, input logic z, e);
        @(negedge clk);
        rst = r; start_i = s; imem_ack_i = a; imem_data_i = d; zero_i = z; ex_done_i = e;
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic req, we, input logic [1:0] sel,
                             input logic busy, halt, err, input logic [15:0] ic,
                             input logic [31:0] ir);
        check({tag, ".imem_req"}, 32'(imem_req_o), 32'(req));
        check({tag, ".pc_we"},    32'(pc_we_o),    32'(we));
        check({tag, ".pc_sel"},   32'(pc_sel_o),   32'(sel));
        check({tag, ".busy"},     32'(busy_o),     32'(busy));
        check({tag, ".halted"},   32'(halted_o),   32'(halt));
        check({tag, ".error"},    32'(error_o),    32'(err));
        check({tag, ".icount"},   32'(icount_o),   32'(ic));
        check({tag, ".ir"},       ir_o,            ir);
    endtask

    localparam logic [31:0] IJmp = 32'h0800_0010;
    localparam logic [31:0] IBeq = 32'h1000_0004;
    localparam logic [31:0] IBne = 32'h1400_0004;
    localparam logic [31:0] IOrd = 32'h2000_0000;
    localparam logic [31:0] IHlt = 32'hFC00_0000;

    initial begin
        //   r s a data  z e   req we sel busy halt err icount ir
        add(1, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0);       // held in reset
        add(0, 1, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0);       // IDLE, start
        add(0, 0, 1, IJmp, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0);       // FETCH, ack jump
        add(0, 0, 0, 0,    0, 0,  0, 1, 2, 1, 0, 0, 0, IJmp);    // DECODE jump
        add(0, 0, 0, 0,    0, 0,  1, 0, 0, 1, 0, 0, 1, IJmp);    // FETCH, no ack
        add(0, 0, 1, IBeq, 0, 0,  1, 0, 0, 1, 0, 0, 1, IJmp);    // FETCH, ack beq
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 1, 0, 0, 1, IBeq);    // DECODE
        add(0, 0, 0, 0,    1, 1,  0, 1, 1, 1, 0, 0, 1, IBeq);    // EXEC beq taken
        add(0, 0, 1, IBeq, 0, 0,  1, 0, 0, 1, 0, 0, 2, IBeq);
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 1, 0, 0, 2, IBeq);
        add(0, 1, 1, IOrd, 1, 0,  0, 0, 0, 1, 0, 0, 2, IBeq);    // EXEC stall, stray start/ack
        add(0, 0, 0, 0,    0, 1,  0, 1, 0, 1, 0, 0, 2, IBeq);    // beq not taken
        add(0, 0, 1, IBne, 0, 0,  1, 0, 0, 1, 0, 0, 3, IBeq);
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 1, 0, 0, 3, IBne);
        add(0, 0, 0, 0,    0, 1,  0, 1, 1, 1, 0, 0, 3, IBne);    // bne taken
        add(0, 0, 1, IBne, 0, 0,  1, 0, 0, 1, 0, 0, 4, IBne);
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 1, 0, 0, 4, IBne);
        add(0, 0, 0, 0,    1, 1,  0, 1, 0, 1, 0, 0, 4, IBne);    // bne not taken
        add(0, 0, 1, IOrd, 0, 0,  1, 0, 0, 1, 0, 0, 5, IBne);
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 1, 0, 0, 5, IOrd);
        add(0, 0, 0, 0,    1, 1,  0, 1, 0, 1, 0, 0, 5, IOrd);    // ordinary ignores zero
        add(0, 0, 1, IHlt, 0, 0,  1, 0, 0, 1, 0, 0, 6, IOrd);
        add(0, 0, 0, 0,    0, 0,  0, 0, 0, 1, 0, 0, 6, IHlt);    // DECODE halt
        add(0, 1, 1, IJmp, 0, 1,  0, 0, 0, 0, 1, 0, 6, IHlt);    // HALT, inputs ignored
        add(0, 1, 0, 0,    0, 0,  0, 0, 0, 0, 1, 0, 6, IHlt);
        add(1, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0, 0, 0);       // async reset

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].z, vecs[i].e);
            check_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].we, vecs[i].sel,
                      vecs[i].busy, vecs[i].halt, vecs[i].err, vecs[i].ic, vecs[i].ir);
        end

        // Ack withheld for 15 FETCH cycles -> ERROR, which is sticky.
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check_all($sformatf("tmo_wait%0d", i), 1, 0, 0, 1, 0, 0, 0, 0);
        end
        drive(0, 1, 1, IJmp, 0, 1);
        check_all("tmo_err", 0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 1, 1, IJmp, 0, 1);
        check_all("tmo_sticky", 0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check_all("tmo_rst", 0, 0, 0, 0, 0, 0, 0, 0);

        // Ack on the 15th wait cycle still reaches DECODE.
        drive(0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 14; i++) drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, IOrd, 0, 0);
        check_all("late_ack", 1, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_all("late_dec", 0, 0, 0, 1, 0, 0, 0, IOrd);
        drive(0, 0, 0, 0, 0, 1);
        check_all("late_exec", 0, 1, 0, 1, 0, 0, 0, IOrd);

        // Reset during EXEC aborts the instruction with no PC write.
        drive(0, 0, 1, IBeq, 0, 0);
        check_all("abort_fetch", 1, 0, 0, 1, 0, 0, 1, IOrd);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0);
        check_all("abort_exec", 0, 0, 0, 1, 0, 0, 1, IBeq);
        drive(1, 0, 0, 0, 1, 1);
        check_all("abort_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        check_all("abort_idle", 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_all("abort_idle2", 0, 0, 0, 0, 0, 0, 0, 0);

        // icount wraps from FFFF to 0000.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        force dut.icount_q = 16'hFFFE;
        #1;
        release dut.icount_q;
        drive(0, 0, 1, IJmp, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_all("wrap_dec1", 0, 1, 2, 1, 0, 0, 16'hFFFE, IJmp);
        drive(0, 0, 1, IJmp, 0, 0);
        check_all("wrap_ffff", 1, 0, 0, 1, 0, 0, 16'hFFFF, IJmp);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check_all("wrap_zero", 1, 0, 0, 1, 0, 0, 16'h0000, IJmp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks,
                 errors);
        $fatal(1);
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max cycles FETCH waits for imem_ack before ERROR.
REQ-002 Parameter OP_HALT, default 6'b111111: opcode that stops the sequencer.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse; leaves IDLE.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_ack  input  1  memory data valid; imem_data sampled this cycle.
REQ-008 imem_data  input  32  instruction word from memory.
REQ-009 zero  input  1  ALU zero flag; sampled only with ex_done.
REQ-010 ex_done  input  1  datapath finished executing current instruction.
REQ-011 ir  output  32  latched current instruction.
REQ-012 pc_we  output  1  one-cycle PC write enable.
REQ-013 pc_sel  output  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target; 3 never driven.
REQ-014 busy  output  1  high in FETCH, DECODE, EXEC.
REQ-015 halted  output  1  high in HALT.
REQ-016 error  output  1  high in ERROR.
REQ-017 icount  output  16  retired-instruction counter.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, HALT, ERROR, Moore outputs except pc_we/pc_sel.
REQ-019 IDLE: start=1 -> FETCH next cycle; else remain.
REQ-020 FETCH: imem_req=1 every cycle; imem_ack=1 -> ir <= imem_data, wait counter cleared, -> DECODE.
REQ-021 FETCH wait counter increments each cycle without ack; ack absent for TIMEOUT consecutive cycles -> ERROR; ack on the TIMEOUT-th cycle wins (-> DECODE).
REQ-022 DECODE lasts exactly one cycle, classifies ir[31:26]: 000010 jump, 000100 beq, 000101 bne, OP_HALT halt, other ordinary.
REQ-023 DECODE jump: pc_we=1, pc_sel=2 that cycle, icount+1, -> FETCH.
REQ-024 DECODE halt: pc_we=0, icount unchanged, -> HALT.
REQ-025 DECODE other: -> EXEC, pc_we=0.
REQ-026 EXEC: wait indefinitely for ex_done; on ex_done: pc_we=1, icount+1, -> FETCH.
REQ-027 EXEC pc_sel on ex_done: 1 if (beq and zero) or (bne and not zero), else 0.
REQ-028 pc_we SHALL be high at most one cycle per instruction; pc_sel=0 whenever pc_we=0.
REQ-029 Fetch-to-PC-update minimum latency: jump 2 cycles after ack (DECODE); ordinary 3 cycles if ex_done arrives first EXEC cycle.
REQ-030 icount wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-031 start outside IDLE ignored; imem_ack outside FETCH ignored; ex_done outside EXEC ignored.
REQ-032 HALT and ERROR sticky; only rst exits; imem_req=0, pc_we=0 there.
REQ-033 imem_req deasserts in the cycle after ack (DECODE); no request in DECODE/EXEC.

Reset
REQ-034 rst=1 SHALL immediately force IDLE, ir=0, icount=0, wait counter=0, all outputs 0, regardless of state or clock.
REQ-035 rst asserted mid-FETCH/EXEC aborts instruction; no pc_we produced; after release block waits in IDLE for start.

Verification
REQ-036 start; ack next cycle with 32'h0800_0010 (j) -> DECODE pc_we=1, pc_sel=2, icount=1, imem_req high next cycle.
REQ-037 beq 32'h1000_0004, ex_done=1 with zero=1 -> pc_sel=1; repeat zero=0 -> pc_sel=0; bne 32'h1400_0004 with zero=0 -> pc_sel=1.
REQ-038 ack withheld 15 cycles in FETCH -> error=1, busy=0; then ack/start -> no change; rst -> IDLE, error=0.
REQ-039 ack on 15th wait cycle -> DECODE, error stays 0.
REQ-040 instruction 32'hFC00_0000 -> halted=1, pc_we never asserted, icount unchanged; start ignored.
REQ-041 preload 65535 retirements (or force) then one more -> icount=0; rst during EXEC -> outputs 0 same cycle, pc_we never pulsed.
